// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and word type for the FWFT controller in front of the negedge RAM.
// DEPTH need not be a power of two; pointers wrap explicitly.
package ram_fifo_ctrl_pkg;
   localparam int DATA_W = 10;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 6;
   localparam int CNT_W  = 3;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/ram_fifo_ctrl_mod_ptr.sv
// Modulo-DEPTH pointer register: clear has priority over increment, wraps DEPTH-1 -> 0.
// Single-cycle update on posedge, asynchronous active-high reset.
module ram_fifo_ctrl_mod_ptr #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] ptr_o
);
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external negedge RAM; 2-cycle empty latency.
// Backpressure: in_ready from registered RAM occupancy only; output register reloads on pop.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = ram_fifo_ctrl_pkg::DATA_W,
   parameter int ADDR_W = ram_fifo_ctrl_pkg::ADDR_W,
   parameter int DEPTH  = ram_fifo_ctrl_pkg::DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        count,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr_w,
   output logic [DATA_W-1:0] ram_datain,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_addr_r,
   input  logic [DATA_W-1:0] ram_dataout
);
   logic [CNT_W-1:0]  mem_count_q, mem_count_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              push, load, pop;

   assign in_ready = (mem_count_q != CNT_W'(DEPTH)) & ~reset & ~flush;
   assign push     = in_valid & in_ready;
   assign load     = (mem_count_q != '0) & (~out_valid_q | out_ready);
   assign ram_read = load & ~reset & ~flush;
   assign pop      = out_valid_q & out_ready;

   assign ram_write  = push;
   assign ram_datain = in_data;

   ram_fifo_ctrl_mod_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_ptr (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (flush),
      .inc_i (push),
      .ptr_o (ram_addr_w)
   );

   ram_fifo_ctrl_mod_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (flush),
      .inc_i (ram_read),
      .ptr_o (ram_addr_r)
   );

   // ram_dataout was refreshed at the mid-cycle negedge when ram_read was high.
   always_comb begin
      mem_count_d = mem_count_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (flush) begin
         mem_count_d = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end else begin
         mem_count_d = mem_count_q + CNT_W'(push) - CNT_W'(ram_read);
         if (ram_read) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_dataout;
         end else if (pop) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_count_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         mem_count_q <= mem_count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign count     = mem_count_q + CNT_W'(out_valid_q);
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 6x10 negedge RAM alongside.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge, before the negedge.
module tb_ram_fifo_ctrl;
   logic       clock;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_data;
   logic [2:0] count;
   logic       ram_write;
   logic [3:0] ram_addr_w;
   logic [9:0] ram_datain;
   logic       ram_read;
   logic [3:0] ram_addr_r;
   logic [9:0] ram_dataout;

   logic [9:0] ram_mem [0:5];

   int errors = 0;
   int checks = 0;

   ram_fifo_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .ram_write   (ram_write),
      .ram_addr_w  (ram_addr_w),
      .ram_datain  (ram_datain),
      .ram_read    (ram_read),
      .ram_addr_r  (ram_addr_r),
      .ram_dataout (ram_dataout)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(negedge clock) begin
      if (ram_write) ram_mem[ram_addr_w] <= ram_datain;
      if (ram_read)  ram_dataout <= ram_mem[ram_addr_r];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1ns after the next posedge, where inputs are driven.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      ram_dataout = '0;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 10'h3C3; out_ready = 1'b0;
      #2;
      chk("rst_count",     16'(count),     16'd0);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_data",  16'(out_data),  16'd0);
      chk("rst_in_ready",  16'(in_ready),  16'd0);
      chk("rst_ram_write", 16'(ram_write), 16'd0);
      chk("rst_ram_read",  16'(ram_read),  16'd0);
      tick();
      reset = 1'b0; in_valid = 1'b0;

      // Reset in the middle of a stream
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 10'h0A1 + 10'(i);
         tick();
      end
      in_valid = 1'b1;
      #1 chk("mid_count_before", 16'(count), 16'd3);
      reset = 1'b1;
      #1;
      chk("mid_rst_count",     16'(count),     16'd0);
      chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
      chk("mid_rst_in_ready",  16'(in_ready),  16'd0);
      chk("mid_rst_ram_write", 16'(ram_write), 16'd0);
      tick();
      reset = 1'b0; in_valid = 1'b0;
      #1 chk("post_rst_in_ready", 16'(in_ready), 16'd1);
      tick();

      // Fill with the consumer stalled: exactly seven accepted
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1'b1; in_data = 10'(k);
         #1 chk($sformatf("fill_in_ready_%0d", k), 16'(in_ready), (k <= 7) ? 16'd1 : 16'd0);
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("full_count",     16'(count),      16'd7);
      chk("full_out_data",  16'(out_data),   16'h001);
      chk("full_out_valid", 16'(out_valid),  16'd1);
      chk("full_in_ready",  16'(in_ready),   16'd0);
      chk("full_wr_ptr",    16'(ram_addr_w), 16'd1);
      tick();

      // Drain from full
      out_ready = 1'b1;
      for (int d = 1; d <= 7; d++) begin
         #1;
         chk($sformatf("drain_data_%0d", d),  16'(out_data),  16'(d));
         chk($sformatf("drain_valid_%0d", d), 16'(out_valid), 16'd1);
         chk($sformatf("drain_count_%0d", d), 16'(count),     16'(8 - d));
         if (d <= 6) chk($sformatf("drain_rd_addr_%0d", d), 16'(ram_addr_r), 16'(d % 6));
         tick();
      end
      #1;
      chk("drained_valid", 16'(out_valid), 16'd0);
      chk("drained_count", 16'(count),     16'd0);
      tick();

      // Flush while empty to bring both pointers back to 0
      flush = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("zero_wr_ptr", 16'(ram_addr_w), 16'd0);
      chk("zero_rd_ptr", 16'(ram_addr_r), 16'd0);
      tick();

      // Empty-FIFO latency
      in_valid = 1'b1; in_data = 10'h2AA;
      #1;
      chk("lat_ram_write", 16'(ram_write),  16'd1);
      chk("lat_addr_w",    16'(ram_addr_w), 16'd0);
      chk("lat_ram_read0", 16'(ram_read),   16'd0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("lat_ram_read1", 16'(ram_read),   16'd1);
      chk("lat_addr_r",    16'(ram_addr_r), 16'd0);
      chk("lat_valid_n1",  16'(out_valid),  16'd0);
      tick();
      #1;
      chk("lat_valid_n2", 16'(out_valid), 16'd1);
      chk("lat_data",     16'(out_data),  16'h2AA);
      chk("lat_count",    16'(count),     16'd1);
      out_ready = 1'b1;
      tick();
      #1 chk("lat_popped", 16'(out_valid), 16'd0);
      tick();

      // Streaming: one item per cycle, order preserved, steady count
      for (int c = 0; c < 22; c++) begin
         in_valid = (c < 20); in_data = 10'h100 + 10'(c);
         #1;
         if (c >= 2) begin
            chk($sformatf("stream_valid_%0d", c), 16'(out_valid), 16'd1);
            chk($sformatf("stream_data_%0d", c),  16'(out_data),  16'h100 + 16'(c - 2));
         end
         if (c >= 2 && c < 20) chk($sformatf("stream_count_%0d", c), 16'(count), 16'd2);
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("stream_end_valid", 16'(out_valid), 16'd0);
      chk("stream_end_count", 16'(count),     16'd0);
      out_ready = 1'b0;
      tick();

      // Flush with four items held; flush beats a concurrent push and load
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 10'h0F1 + 10'(i);
         tick();
      end
      #1 chk("flush_pre_count", 16'(count), 16'd4);
      flush = 1'b1; in_valid = 1'b1; in_data = 10'h3FF; out_ready = 1'b1;
      #1;
      chk("flush_in_ready",  16'(in_ready),  16'd0);
      chk("flush_ram_write", 16'(ram_write), 16'd0);
      chk("flush_ram_read",  16'(ram_read),  16'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("flushed_count",    16'(count),      16'd0);
      chk("flushed_valid",    16'(out_valid),  16'd0);
      chk("flushed_out_data", 16'(out_data),   16'd0);
      chk("flushed_wr_ptr",   16'(ram_addr_w), 16'd0);
      chk("flushed_rd_ptr",   16'(ram_addr_r), 16'd0);
      in_valid = 1'b1; in_data = 10'h155;
      tick();
      in_valid = 1'b0;
      tick();
      #1;
      chk("after_flush_valid", 16'(out_valid), 16'd1);
      chk("after_flush_data",  16'(out_data),  16'h155);
      chk("after_flush_count", 16'(count),     16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
